// File: rtl/mngr_pkg.sv
// Shared types and constants for the mngr stream agent slice.
//   mngr_msg_t        32-bit stream word
//   mngr_state_e      agent run state: IDLE, RUN, PASS, FAIL
//   MNGR_TIMEOUT_GOT  word reported as fail_got when the idle watchdog fires
package mngr_pkg;

  typedef logic [31:0] mngr_msg_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PASS,
    FAIL
  } mngr_state_e;

  localparam mngr_msg_t MNGR_TIMEOUT_GOT = 32'hDEAD_0000;

endpackage

// File: rtl/mngr_stream_agent_if.sv
// Handshake bundle between the manager agent and the processor.
//   mngr2proc_msg/val/rdy  manager -> processor source stream
//   proc2mngr_msg/val/rdy  processor -> manager sink stream
// Modports: master = manager side, slave = processor side.
interface mngr_stream_agent_if;
  import mngr_pkg::*;

  mngr_msg_t mngr2proc_msg;
  logic      mngr2proc_val;
  logic      mngr2proc_rdy;
  mngr_msg_t proc2mngr_msg;
  logic      proc2mngr_val;
  logic      proc2mngr_rdy;

  modport master (
    output mngr2proc_msg,
    output mngr2proc_val,
    input  mngr2proc_rdy,
    input  proc2mngr_msg,
    input  proc2mngr_val,
    output proc2mngr_rdy
  );

  modport slave (
    input  mngr2proc_msg,
    input  mngr2proc_val,
    output mngr2proc_rdy,
    output proc2mngr_msg,
    output proc2mngr_val,
    input  proc2mngr_rdy
  );

endinterface

// File: rtl/mngr_table.sv
// DEPTH x 32 register file: one synchronous write port, one asynchronous
// read port. Contents are not reset.
//   clk          clock
//   we/waddr/wdata  write port (lands at posedge)
//   raddr/rdata     combinational read port
module mngr_table
  import mngr_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  mngr_msg_t     wdata,
  input  logic [AW-1:0] raddr,
  output mngr_msg_t     rdata
);

  mngr_msg_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mngr_stream_agent.sv
// Manager end of the mngr stream interface. Streams a preloaded source table
// to the processor and checks returned words against a preloaded expected
// table, reporting pass/fail and first-mismatch details.
//   clk, rst              clock, asynchronous active-high reset
//   cfg_we/sel/addr/data  table load port (IDLE only; sel 0 = source, 1 = expected)
//   src_cnt, exp_cnt      word counts, sampled on start
//   start                 pulse: IDLE/PASS/FAIL -> RUN
//   bus (master)          mngr2proc / proc2mngr handshakes
//   done, pass            run result, sticky until next start
//   fail_idx/got/exp      first mismatch details
// Optional: define MNGR_TIMEOUT_EN to enable the idle-cycle watchdog
// (TIMEOUT_CYC RUN cycles without any transfer -> FAIL).
module mngr_stream_agent
  import mngr_pkg::*;
#(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned AW          = $clog2(DEPTH),
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic                cfg_sel,
  input  logic [AW-1:0]       cfg_addr,
  input  mngr_msg_t           cfg_data,
  input  logic [AW:0]         src_cnt,
  input  logic [AW:0]         exp_cnt,
  input  logic                start,
  mngr_stream_agent_if.master bus,
  output logic                done,
  output logic                pass,
  output logic [AW:0]         fail_idx,
  output mngr_msg_t           fail_got,
  output mngr_msg_t           fail_exp
);

  typedef logic [AW:0] ptr_t;

  mngr_state_e state_q, state_d;
  ptr_t        src_ptr_q, src_ptr_d, exp_ptr_q, exp_ptr_d;
  ptr_t        src_cnt_q, src_cnt_d, exp_cnt_q, exp_cnt_d;
  ptr_t        fail_idx_q, fail_idx_d;
  mngr_msg_t   fail_got_q, fail_got_d, fail_exp_q, fail_exp_d;
  mngr_msg_t   src_rd, exp_rd;
  logic        src_val, snk_rdy, src_xfer, snk_xfer;
  logic        cfg_ok;

`ifdef MNGR_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] to_cnt_q, to_cnt_d;
`else
  // Watchdog compiled out; the parameter stays so overrides remain legal.
  if (TIMEOUT_CYC == 0) begin : g_no_timeout
  end
`endif

  assign cfg_ok = cfg_we && (state_q == IDLE);

  mngr_table #(.DEPTH(DEPTH), .AW(AW)) u_src_tab (
    .clk   (clk),
    .we    (cfg_ok && !cfg_sel),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (src_ptr_q[AW-1:0]),
    .rdata (src_rd)
  );

  mngr_table #(.DEPTH(DEPTH), .AW(AW)) u_exp_tab (
    .clk   (clk),
    .we    (cfg_ok && cfg_sel),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (exp_ptr_q[AW-1:0]),
    .rdata (exp_rd)
  );

  always_comb begin
    state_d    = state_q;
    src_ptr_d  = src_ptr_q;
    exp_ptr_d  = exp_ptr_q;
    src_cnt_d  = src_cnt_q;
    exp_cnt_d  = exp_cnt_q;
    fail_idx_d = fail_idx_q;
    fail_got_d = fail_got_q;
    fail_exp_d = fail_exp_q;
    src_val    = 1'b0;
    snk_rdy    = 1'b0;
    src_xfer   = 1'b0;
    snk_xfer   = 1'b0;
`ifdef MNGR_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
`endif
    case (state_q)
      RUN: begin
        src_val  = (src_ptr_q < src_cnt_q);
        snk_rdy  = (exp_ptr_q < exp_cnt_q);
        src_xfer = src_val && bus.mngr2proc_rdy;
        snk_xfer = snk_rdy && bus.proc2mngr_val;
        if (src_xfer) src_ptr_d = src_ptr_q + ptr_t'(1);
        if (snk_xfer && (bus.proc2mngr_msg == exp_rd)) exp_ptr_d = exp_ptr_q + ptr_t'(1);
`ifdef MNGR_TIMEOUT_EN
        to_cnt_d = (src_xfer || snk_xfer) ? '0 : to_cnt_q + 16'd1;
`endif
        // Completion looks at registered pointers, so PASS lands one cycle
        // after the last transfer; a mismatch always wins.
        if (snk_xfer && (bus.proc2mngr_msg != exp_rd)) begin
          state_d    = FAIL;
          fail_idx_d = exp_ptr_q;
          fail_got_d = bus.proc2mngr_msg;
          fail_exp_d = exp_rd;
        end else if ((src_ptr_q == src_cnt_q) && (exp_ptr_q == exp_cnt_q)) begin
          state_d = PASS;
        end
`ifdef MNGR_TIMEOUT_EN
        else if (!src_xfer && !snk_xfer && (to_cnt_q == TO_LAST)) begin
          state_d    = FAIL;
          fail_idx_d = exp_ptr_q;
          fail_got_d = MNGR_TIMEOUT_GOT;
          fail_exp_d = exp_rd;
        end
`endif
      end
      default: begin
        // IDLE, PASS and FAIL all (re)start a run on start.
        if (start) begin
          state_d    = RUN;
          src_cnt_d  = src_cnt;
          exp_cnt_d  = exp_cnt;
          src_ptr_d  = '0;
          exp_ptr_d  = '0;
          fail_idx_d = '0;
          fail_got_d = '0;
          fail_exp_d = '0;
`ifdef MNGR_TIMEOUT_EN
          to_cnt_d   = '0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      src_ptr_q  <= '0;
      exp_ptr_q  <= '0;
      src_cnt_q  <= '0;
      exp_cnt_q  <= '0;
      fail_idx_q <= '0;
      fail_got_q <= '0;
      fail_exp_q <= '0;
`ifdef MNGR_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      src_ptr_q  <= src_ptr_d;
      exp_ptr_q  <= exp_ptr_d;
      src_cnt_q  <= src_cnt_d;
      exp_cnt_q  <= exp_cnt_d;
      fail_idx_q <= fail_idx_d;
      fail_got_q <= fail_got_d;
      fail_exp_q <= fail_exp_d;
`ifdef MNGR_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
`endif
    end
  end

  assign bus.mngr2proc_val = src_val;
  assign bus.mngr2proc_msg = (state_q == RUN) ? src_rd : '0;
  assign bus.proc2mngr_rdy = snk_rdy;
  assign done              = (state_q == PASS) || (state_q == FAIL);
  assign pass              = (state_q == PASS);
  assign fail_idx          = fail_idx_q;
  assign fail_got          = fail_got_q;
  assign fail_exp          = fail_exp_q;

endmodule

// File: tb/tb_mngr_stream_agent.sv
// Self-checking bench for mngr_stream_agent: randomized processor stalls and
// tables, scoreboard of expected source words popped by a monitor, and a
// table-level model of the expected pass/fail outcome.
module tb_mngr_stream_agent;
  import mngr_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  typedef logic [AW:0] cnt_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we, cfg_sel;
  logic [AW-1:0] cfg_addr;
  mngr_msg_t   cfg_data;
  cnt_t        src_cnt, exp_cnt;
  logic        start;
  logic        done, pass;
  cnt_t        fail_idx;
  mngr_msg_t   fail_got, fail_exp;

  mngr_stream_agent_if bus();

  mngr_stream_agent #(
    .DEPTH(DEPTH),
    .AW(AW)
`ifdef MNGR_TIMEOUT_EN
    , .TIMEOUT_CYC(16)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_sel  (cfg_sel),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .src_cnt  (src_cnt),
    .exp_cnt  (exp_cnt),
    .start    (start),
    .bus      (bus),
    .done     (done),
    .pass     (pass),
    .fail_idx (fail_idx),
    .fail_got (fail_got),
    .fail_exp (fail_exp)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference tables and processor responses.
  mngr_msg_t src_a [DEPTH];
  mngr_msg_t exp_a [DEPTH];
  mngr_msg_t resp_a [DEPTH+4];
  int        resp_n;

  // Scoreboard / monitor state.
  mngr_msg_t src_q [$];
  mngr_msg_t resp_q [$];
  bit        drv_en = 1'b0;
  int unsigned rdy_pct = 100, val_pct = 100;
  int        src_xfers, snk_xfers;
  int        cyc = 0, last_xfer_cyc = -1, done_cyc = -1;
  int        exp_mm;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, want);
    end
  endtask

  // Monitor: pops expected source words on every source transfer.
  initial begin : monitor
    bit        stall_prev;
    mngr_msg_t msg_prev;
    stall_prev = 1'b0;
    msg_prev   = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (stall_prev && !done) begin
          check("src_val_hold", 32'(bus.mngr2proc_val), 32'd1);
          check("src_msg_hold", bus.mngr2proc_msg, msg_prev);
        end
        if (bus.mngr2proc_val && bus.mngr2proc_rdy) begin
          src_xfers++;
          last_xfer_cyc = cyc;
          if (src_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL src_extra: got word 0x%08h, required no transfer", bus.mngr2proc_msg);
          end else begin
            check("src_msg", bus.mngr2proc_msg, src_q.pop_front());
          end
        end
        if (bus.proc2mngr_val && bus.proc2mngr_rdy) begin
          snk_xfers++;
          last_xfer_cyc = cyc;
        end
        if (done && done_cyc < 0) done_cyc = cyc;
      end
      stall_prev = !rst && bus.mngr2proc_val && !bus.mngr2proc_rdy;
      msg_prev   = bus.mngr2proc_msg;
    end
  end

  // Processor model: random ready on the source side, random valid on the
  // sink side; a presented word stays until it is accepted.
  initial begin : proc_drv
    bit acc;
    forever begin
      @(negedge clk);
      acc = bus.proc2mngr_val && bus.proc2mngr_rdy && !rst;
      @(posedge clk);
      #1;
      if (acc && resp_q.size() > 0) void'(resp_q.pop_front());
      if (!drv_en) begin
        bus.mngr2proc_rdy = 1'b0;
        bus.proc2mngr_val = 1'b0;
      end else begin
        bus.mngr2proc_rdy = ($urandom_range(99, 0) < rdy_pct);
        if (resp_q.size() == 0)
          bus.proc2mngr_val = 1'b0;
        else if (!(bus.proc2mngr_val && !acc))
          bus.proc2mngr_val = ($urandom_range(99, 0) < val_pct);
      end
      bus.proc2mngr_msg = (resp_q.size() > 0) ? resp_q[0] : '0;
    end
  end

  task automatic hard_reset();
    drv_en = 1'b0;
    rst = 1'b1;
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic load_tables();
    for (int i = 0; i < DEPTH; i++) begin
      cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = AW'(i); cfg_data = src_a[i];
      @(posedge clk); #1;
      cfg_sel = 1'b1; cfg_data = exp_a[i];
      @(posedge clk); #1;
    end
    cfg_we = 1'b0;
  endtask

  task automatic randomize_tables();
    for (int i = 0; i < DEPTH; i++) begin
      src_a[i] = $urandom;
      exp_a[i] = $urandom;
    end
  endtask

  // Model: the outcome depends only on the first response differing from
  // the expected table within exp_cnt words.
  task automatic prep(input int scnt, input int ecnt);
    exp_mm = -1;
    for (int i = 0; i < ecnt; i++) begin
      if (resp_a[i] != exp_a[i]) begin
        exp_mm = i;
        break;
      end
    end
    src_q.delete();
    for (int i = 0; i < scnt; i++) src_q.push_back(src_a[i]);
    resp_q.delete();
    for (int i = 0; i < resp_n; i++) resp_q.push_back(resp_a[i]);
    src_xfers = 0;
    snk_xfers = 0;
  endtask

  task automatic pulse_start(input int scnt, input int ecnt);
    src_cnt = cnt_t'(scnt);
    exp_cnt = cnt_t'(ecnt);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_cyc = -1;
    last_xfer_cyc = -1;
  endtask

  task automatic finish_case(input string tag, input int scnt, input int ecnt);
    int c = 0;
    while (!done && c < 3000) begin
      @(negedge clk);
      c++;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_wait: done=0 after %0d cycles, required done=1", tag, c);
    end else begin
      @(negedge clk);
      check({tag, "_pass"}, 32'(pass), 32'(exp_mm < 0));
      if (exp_mm < 0) begin
        check({tag, "_src_xfers"}, src_xfers, scnt);
        check({tag, "_snk_xfers"}, snk_xfers, ecnt);
        check({tag, "_src_left"}, src_q.size(), 0);
        if (last_xfer_cyc >= 0)
          check({tag, "_latency"}, done_cyc - last_xfer_cyc, 2);
      end else begin
        check({tag, "_fail_idx"}, 32'(fail_idx), exp_mm);
        check({tag, "_fail_got"}, fail_got, resp_a[exp_mm]);
        check({tag, "_fail_exp"}, fail_exp, exp_a[exp_mm]);
        check({tag, "_snk_xfers"}, snk_xfers, exp_mm + 1);
      end
    end
    drv_en = 1'b0;
    src_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic run_case(input string tag, input int scnt, input int ecnt,
                          input int unsigned rp, input int unsigned vp, input bit poke);
    prep(scnt, ecnt);
    pulse_start(scnt, ecnt);
    if (poke) begin
      // A second start while running must be ignored.
      repeat (2) @(posedge clk);
      #1;
      pulse_start(0, 0);
      @(negedge clk);
      check({tag, "_start_in_run"}, 32'(done), 32'd0);
      @(posedge clk); #1;
    end
    rdy_pct = rp;
    val_pct = vp;
    drv_en  = 1'b1;
    finish_case(tag, scnt, ecnt);
  endtask

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin : main
    int c;
    rst = 1'b1; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0;
    src_cnt = '0; exp_cnt = '0; start = 1'b0;
    bus.mngr2proc_rdy = 1'b0; bus.proc2mngr_val = 1'b0; bus.proc2mngr_msg = '0;
    #12;
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_fail_idx", 32'(fail_idx), 32'd0);
    check("rst_fail_got", fail_got, 32'd0);
    check("rst_fail_exp", fail_exp, 32'd0);
    check("rst_src_val", 32'(bus.mngr2proc_val), 32'd0);
    check("rst_src_msg", bus.mngr2proc_msg, 32'd0);
    check("rst_snk_rdy", 32'(bus.proc2mngr_rdy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Echo test: src {1,2,3}, exp {3,2,1}.
    randomize_tables();
    src_a[0] = 1; src_a[1] = 2; src_a[2] = 3;
    exp_a[0] = 3; exp_a[1] = 2; exp_a[2] = 1;
    load_tables();
    resp_n = 3; resp_a[0] = 3; resp_a[1] = 2; resp_a[2] = 1;
    run_case("echo", 3, 3, 100, 100, 1'b0);

    // cfg writes outside IDLE must not land; re-run with stalls from PASS.
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    run_case("stall", 3, 3, 50, 50, 1'b1);

    // Mismatch: exp {5,6,7}, proc returns {5,9,7}.
    hard_reset();
    exp_a[0] = 5; exp_a[1] = 6; exp_a[2] = 7;
    load_tables();
    resp_n = 3; resp_a[0] = 5; resp_a[1] = 9; resp_a[2] = 7;
    run_case("mism", 3, 3, 100, 100, 1'b0);

    // Zero counts: PASS on the second cycle after start, no handshakes.
    hard_reset();
    resp_n = 0;
    prep(0, 0);
    drv_en = 1'b1; rdy_pct = 100; val_pct = 100;
    pulse_start(0, 0);
    @(negedge clk);
    check("cnt0_done_c1", 32'(done), 32'd0);
    check("cnt0_val_c1", 32'(bus.mngr2proc_val), 32'd0);
    check("cnt0_rdy_c1", 32'(bus.proc2mngr_rdy), 32'd0);
    @(negedge clk);
    check("cnt0_done_c2", 32'(done), 32'd1);
    check("cnt0_pass_c2", 32'(pass), 32'd1);
    drv_en = 1'b0;
    @(posedge clk); #1;

    // Reset mid-run after two source transfers, then re-run from src_tab[0].
    hard_reset();
    randomize_tables();
    load_tables();
    resp_n = 0;
    prep(2, 1);
    pulse_start(2, 1);
    rdy_pct = 100; val_pct = 100; drv_en = 1'b1;
    c = 0;
    while (src_xfers < 2 && c < 50) begin
      @(negedge clk);
      c++;
    end
    @(posedge clk); #1;
    check("midrst_xfers", src_xfers, 2);
    rst = 1'b1;
    drv_en = 1'b0;
    #1;
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_src_val", 32'(bus.mngr2proc_val), 32'd0);
    check("midrst_src_msg", bus.mngr2proc_msg, 32'd0);
    check("midrst_snk_rdy", 32'(bus.proc2mngr_rdy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_case("after_rst", 3, 0, 100, 100, 1'b0);

`ifdef MNGR_TIMEOUT_EN
    // Watchdog: processor never sends.
    hard_reset();
    resp_n = 0;
    prep(0, 1);
    drv_en = 1'b1; rdy_pct = 100; val_pct = 100;
    pulse_start(0, 1);
    c = 0;
    while (!done && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("to_cycles", c, 17);
    check("to_pass", 32'(pass), 32'd0);
    check("to_fail_idx", 32'(fail_idx), 32'd0);
    check("to_fail_got", fail_got, 32'hDEAD_0000);
    check("to_fail_exp", fail_exp, exp_a[0]);
    drv_en = 1'b0;
    @(posedge clk); #1;
`endif

    // Randomized runs: random tables, counts, stalls, extras and mismatches.
    for (int it = 0; it < 8; it++) begin
      int scnt, ecnt, k;
      hard_reset();
      randomize_tables();
      load_tables();
      scnt = $urandom_range(DEPTH, 0);
      ecnt = $urandom_range(DEPTH, 0);
      resp_n = ecnt + $urandom_range(3, 0);
      for (int i = 0; i < resp_n; i++) resp_a[i] = (i < ecnt) ? exp_a[i] : $urandom;
      if (ecnt > 0 && $urandom_range(1, 0) == 1) begin
        k = $urandom_range(ecnt - 1, 0);
        resp_a[k] = resp_a[k] ^ (32'h1 << $urandom_range(31, 0));
      end
      run_case($sformatf("rnd%0d", it), scnt, ecnt,
               $urandom_range(100, 40), $urandom_range(100, 40), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
